cla_operand_sequencer: RTL and testbench

//  Upstream stage of the registered 16-bit CLA adder. Accepts one wide add (NCHUNK*CHUNK_W bits) via

---
 rtl/cla_operand_sequencer.sv | 111 +++++++++++
 tb/tb_cla_operand_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_operand_sequencer.sv
// cla_operand_sequencer
// Splits one wide add into CHUNK_W slices and sends them, LSB slice first, to a registered
// CHUNK_W-bit adder. The carry passes from slice to slice through a register. The slice sums
// are collected into the full-width result, which is offered with a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for new operands (in_ready=1)
// ISSUE | present slice idx to the adder for one cycle and load the latency counter
// WAIT  | hold the adder inputs for ADD_LAT cycles, then capture the slice sum and carry
// DONE  | full result valid, waiting for out_ready
module cla_operand_sequencer #(
  parameter int CHUNK_W = 16,
  parameter int NCHUNK  = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHUNK_W*NCHUNK-1:0]   in_a,
  input  logic [CHUNK_W*NCHUNK-1:0]   in_b,
  input  logic                        in_cin,
  output logic [CHUNK_W-1:0]          add_a,
  output logic [CHUNK_W-1:0]          add_b,
  output logic                        add_cin,
  input  logic [CHUNK_W-1:0]          add_sum,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHUNK_W*NCHUNK-1:0]   out_sum,
  output logic                        out_cout,
  output logic                        busy
);

  localparam int W     = CHUNK_W * NCHUNK;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [W-1:0]     a_q, b_q, res_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = (idx == IDX_LAST) ? DONE : ISSUE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the operands, step through the slices and collect the slice sums.
  // add_sum/add_cout are sampled only on the edge that leaves WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          carry <= in_cin;
          idx   <= '0;
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == '0) begin
            res_q[idx*CHUNK_W +: CHUNK_W] <= add_sum;
            carry                         <= add_cout;
            if (idx != IDX_LAST) idx <= idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // idx and carry do not change during ISSUE and WAIT, so the adder inputs stay stable
  assign add_a     = a_q[idx*CHUNK_W +: CHUNK_W];
  assign add_b     = b_q[idx*CHUNK_W +: CHUNK_W];
  assign add_cin   = carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = res_q;
  assign out_cout  = carry;

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Directed and random bench for cla_operand_sequencer. Expected results go into a queue at accept
// time and are compared when the result handshake takes place.
module tb_cla_operand_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic        out_cout0, out_cout1, add_cin0, add_cin1, add_cout0, add_cout1;
  logic [63:0] out_sum0, out_sum1;
  logic [15:0] add_a0, add_b0, add_a1, add_b1, add_sum0, add_sum1;

  // adder models: ADD_LAT-deep registered 16-bit adders
  logic [16:0] p0_s0, p0_s1;
  logic [16:0] p1_s0, p1_s1, p1_s2;

  always @(posedge clk) begin
    p0_s0 <= {1'b0, add_a0} + {1'b0, add_b0} + {16'd0, add_cin0};
    p0_s1 <= p0_s0;
    p1_s0 <= {1'b0, add_a1} + {1'b0, add_b1} + {16'd0, add_cin1};
    p1_s1 <= p1_s0;
    p1_s2 <= p1_s1;
  end

  assign add_sum0  = p0_s1[15:0];
  assign add_cout0 = p0_s1[16];
  assign add_sum1  = p1_s2[15:0];
  assign add_cout1 = p1_s2[16];

  cla_operand_sequencer #(.CHUNK_W(16), .NCHUNK(4), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
    .add_sum(add_sum0), .add_cout(add_cout0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(out_sum0), .out_cout(out_cout0), .busy(busy0)
  );

  cla_operand_sequencer #(.CHUNK_W(16), .NCHUNK(4), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  typedef struct packed {
    logic        cout;
    logic [63:0] sum;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    return s;
  endfunction

  function automatic logic rdy(input int d);
    return (d != 0) ? in_ready1 : in_ready0;
  endfunction
  function automatic logic ov(input int d);
    return (d != 0) ? out_valid1 : out_valid0;
  endfunction
  function automatic logic [63:0] osum(input int d);
    return (d != 0) ? out_sum1 : out_sum0;
  endfunction
  function automatic logic ocout(input int d);
    return (d != 0) ? out_cout1 : out_cout0;
  endfunction

  task automatic set_iv(input int d, input logic v);
    if (d != 0) in_valid1 = v;
    else        in_valid0 = v;
  endtask
  task automatic set_or(input int d, input logic v);
    if (d != 0) out_ready1 = v;
    else        out_ready0 = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for in_ready, record the expected result. Returns at the negedge after accept.
  task automatic send(input int d, input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input bit keep, output int waited);
    in_a = a; in_b = b; in_cin = cin;
    set_iv(d, 1'b1);
    waited = 0;
    while (!rdy(d) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy(d)) chk("accept_timeout", rdy(d), 1);
    q.push_back(model(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    if (!keep) set_iv(d, 1'b0);
  endtask

  // Wait for out_valid (expecting cycle lat after accept), optionally stall, then check and handshake.
  task automatic collect(input int d, input int lat, input bit keep_ready, input int stall);
    int   n;
    exp_t e;
    n = 1;
    while (!ov(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    if (q.size() == 0) begin
      chk("queue_empty", q.size(), 1);
      return;
    end
    e = q.pop_front();
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", ov(d), 1);
      chk("stall_sum", osum(d), e.sum);
      chk("stall_in_ready", rdy(d), 0);
      @(negedge clk);
    end
    chk("out_sum", osum(d), e.sum);
    chk("out_cout", ocout(d), e.cout);
    set_or(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_hs", rdy(d), 1);
    chk("valid_after_hs", ov(d), 0);
    if (!keep_ready) set_or(d, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // reset values
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_add_a", add_a0, 0);
    chk("rst_add_b", add_b0, 0);
    chk("rst_add_cin", add_cin0, 0);
    chk("rst_out_sum", out_sum0, 0);
    chk("rst_out_cout", out_cout0, 0);
    chk("rst_in_ready_l3", in_ready1, 1);
    rst = 1'b1;
    @(negedge clk);

    // carry ripples through every slice
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, w);
    collect(0, 13, 1'b0, 0);

    // per-slice sums with carry-in
    send(0, 64'h0001_0002_0003_0004, 64'h1000_2000_3000_4000, 1'b1, 1'b0, w);
    collect(0, 13, 1'b0, 0);

    // backpressure with a new request held the whole time
    send(0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b1, 1'b0, w);
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_cin = 1'b0;
    in_valid0 = 1'b1;
    collect(0, 13, 1'b0, 5);
    send(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, w);
    chk("held_accept_wait", w, 0);
    collect(0, 13, 1'b0, 0);

    // reset during slice 2 WAIT
    send(0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b0, w);
    repeat (7) @(negedge clk);
    chk("mid_busy", busy0, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready0, 1);
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_busy", busy0, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 64'd5, 64'd7, 1'b0, 1'b0, w);
    collect(0, 13, 1'b0, 0);

    // back-to-back with in_valid and out_ready held high
    out_ready0 = 1'b1;
    send(0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1, w);
    in_a = 64'hDEAD_BEEF_0000_0001; in_b = 64'h2152_4110_FFFF_FFFF; in_cin = 1'b1;
    collect(0, 13, 1'b1, 0);
    send(0, 64'hDEAD_BEEF_0000_0001, 64'h2152_4110_FFFF_FFFF, 1'b1, 1'b0, w);
    chk("b2b_accept_wait", w, 0);
    collect(0, 13, 1'b0, 0);
    out_ready0 = 1'b0;

    // ADD_LAT=3, random operands
    for (int i = 0; i < 1000; i++) begin
      send(1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b0, w);
      collect(1, 17, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
